cfi_log_queue: RTL and testbench
================================

CFI_LOG_QUEUE -- requirements
Module: cfi_log_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of log entries; SHALL be a power of two, 2..64.
REQ-002 Parameter STALL_MARGIN, default 2, free-slot threshold that raises stall_o; SHALL be 1..DEPTH-1.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 flush_i  input  1  synchronous clear of all entries.
REQ-006 push_i  input  1  commit stage presents a CFI log entry this cycle.
REQ-007 log_i  input  cfi_log_t (cfi_pkg, 256 bits)  entry data captured on accepted push.
REQ-008 stall_o  output  1  request to commit stage to stop retiring control-flow instructions.
REQ-009 full_o  output  1  no free slot.
REQ-010 log_o  output  cfi_log_t  head entry toward the CFI backend.
REQ-011 queue_empty_o  output  1  no valid entry; log_o is don't-care when high.
REQ-012 queue_pop_i  input  1  backend consumed the head entry.
REQ-013 usage_o  output  $clog2(DEPTH)+1  number of valid entries.
REQ-014 overflow_o  output  1  sticky flag: at least one push was dropped.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH entries with read pointer, write pointer and occupancy counter, each wrapping modulo DEPTH.
REQ-016 log_o SHALL be driven combinationally from the entry at the read pointer; no output register, zero-cycle read latency.
REQ-017 A push SHALL be accepted when push_i=1 and (full_o=0 or queue_pop_i=1 with queue_empty_o=0); accepted data is written at the write pointer, which then increments.
REQ-018 A push while full without a same-cycle pop SHALL be dropped, leave the contents unchanged and set overflow_o.
REQ-019 A pop SHALL take effect only when queue_pop_i=1 and queue_empty_o=0; the read pointer then increments. A pop while empty SHALL be ignored with no state change.
REQ-020 Simultaneous accepted push and pop SHALL leave usage_o unchanged and advance both pointers; when empty, push+pop SHALL accept the push and ignore the pop (no fall-through).
REQ-021 A pushed entry SHALL appear on log_o no earlier than the cycle after its push.
REQ-022 usage_o SHALL be +1 on push-only, -1 on pop-only, unchanged otherwise; it SHALL never exceed DEPTH or underflow.
REQ-023 full_o SHALL equal (usage_o == DEPTH); queue_empty_o SHALL equal (usage_o == 0).
REQ-024 stall_o SHALL equal (DEPTH - usage_o <= STALL_MARGIN), combinational from registered occupancy.
REQ-025 flush_i SHALL take priority over push and pop: next cycle pointers=0, usage_o=0, queue_empty_o=1; overflow_o SHALL be preserved.
REQ-026 overflow_o SHALL clear only on reset.
REQ-027 Entry storage SHALL need no reset; only pointers, counter and overflow flag are reset.

Reset
REQ-028 On rst_ni low, asynchronously: read pointer=0, write pointer=0, usage_o=0, queue_empty_o=1, full_o=0, stall_o=0 (DEPTH > STALL_MARGIN), overflow_o=0.
REQ-029 Assertion of rst_ni mid-operation SHALL discard all entries; the first push after release lands at index 0.
REQ-030 Pushes and pops with rst_ni low SHALL be ignored.

Verification
REQ-031 DEPTH=8, push A..D on 4 cycles, no pop -> usage_o=4, log_o=A, queue_empty_o=0, stall_o=0.
REQ-032 DEPTH=8, push 6 entries -> stall_o=1 at usage_o=6; push 2 more -> full_o=1; 9th push without pop -> dropped, overflow_o=1, usage_o=8, log_o unchanged.
REQ-033 Full queue, push X with pop same cycle -> usage_o stays 8, head advances, X is the 8th entry after pop order, overflow_o not set.
REQ-034 Empty queue, push A with queue_pop_i=1 -> A accepted, usage_o=1, next cycle log_o=A.
REQ-035 Fill 5, pop 5, push 10 with interleaved pops -> pointer wrap; pop order equals push order, usage_o never >8 or <0.
REQ-036 Usage 3, overflow_o=1, flush_i with push_i=1 -> next cycle usage_o=0, queue_empty_o=1, overflow_o=1; rst_ni pulse -> overflow_o=0.

Source files
------------

// File: rtl/cfi_log_queue.sv
// CFI log package and queue: circular buffer buffering commit-stage CFI log
// entries toward the backend, with stall back-pressure and a sticky drop flag.
package cfi_pkg;
  typedef logic [255:0] cfi_log_t;
endpackage

module cfi_log_queue
  import cfi_pkg::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned STALL_MARGIN = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  cfi_log_t                 log_i,
  output logic                     stall_o,
  output logic                     full_o,
  output cfi_log_t                 log_o,
  output logic                     queue_empty_o,
  input  logic                     queue_pop_i,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     overflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned UW = PW + 1;

  cfi_log_t          mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [UW-1:0]     usage_q, usage_d;
  logic              overflow_q, overflow_d;

  logic              pop_ok;
  logic              push_ok;
  logic              write_en;

  assign full_o        = (usage_q == UW'(DEPTH));
  assign queue_empty_o = (usage_q == '0);
  assign stall_o       = ((UW'(DEPTH) - usage_q) <= UW'(STALL_MARGIN));
  assign usage_o       = usage_q;
  assign overflow_o    = overflow_q;
  assign log_o         = mem_q[rd_ptr_q];

  // A pop on a full queue frees the slot the same-cycle push needs.
  assign pop_ok   = queue_pop_i & ~queue_empty_o;
  assign push_ok  = push_i & (~full_o | pop_ok);
  assign write_en = push_ok & ~flush_i;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    usage_d    = usage_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      usage_d = usage_q + UW'(1);
      else if (pop_ok && !push_ok) usage_d = usage_q - UW'(1);
      if (push_i && !push_ok) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      usage_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      usage_q    <= usage_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (write_en) mem_q[wr_ptr_q] <= log_i;
  end

endmodule

// File: tb/tb_cfi_log_queue.sv
// Directed self-checking bench for cfi_log_queue at DEPTH=8, STALL_MARGIN=2.
module tb_cfi_log_queue;
  import cfi_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       flush_i;
  logic       push_i;
  cfi_log_t   log_i;
  logic       stall_o;
  logic       full_o;
  cfi_log_t   log_o;
  logic       queue_empty_o;
  logic       queue_pop_i;
  logic [3:0] usage_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_fail   = 0;
  cfi_log_t mq[$];

  cfi_log_queue #(.DEPTH(8), .STALL_MARGIN(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i),
    .log_i(log_i), .stall_o(stall_o), .full_o(full_o), .log_o(log_o),
    .queue_empty_o(queue_empty_o), .queue_pop_i(queue_pop_i),
    .usage_o(usage_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic cfi_log_t mk(input int n);
    return {8{32'h0A0B_0000 + n}};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then sample 1ns after the rising edge.
  task automatic step(input logic push, input logic pop, input logic flush, input cfi_log_t d);
    push_i = push; queue_pop_i = pop; flush_i = flush; log_i = d;
    @(posedge clk_i); #1;
    push_i = 1'b0; queue_pop_i = 1'b0; flush_i = 1'b0;
    $display("t=%0t push=%0b pop=%0b flush=%0b usage=%0d empty=%0b full=%0b stall=%0b ovf=%0b head=%0h",
             $time, push, pop, flush, usage_o, queue_empty_o, full_o, stall_o, overflow_o, log_o[31:0]);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; push_i = 1'b0; queue_pop_i = 1'b0; log_i = '0;
    #2;
    check("rst_usage", usage_o, 0);
    check("rst_empty", queue_empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_ovf", overflow_o, 0);
    step(1'b1, 1'b0, 1'b0, mk(99));
    check("push_in_reset", usage_o, 0);
    rst_ni = 1'b1;

    // Push A..D
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, mk(i));
    check("abcd_usage", usage_o, 4);
    check("abcd_head", log_o, mk(1));
    check("abcd_empty", queue_empty_o, 0);
    check("abcd_stall", stall_o, 0);
    step(1'b1, 1'b0, 1'b0, mk(5));
    check("u5_stall", stall_o, 0);
    step(1'b1, 1'b0, 1'b0, mk(6));
    check("u6_stall", stall_o, 1);
    check("u6_usage", usage_o, 6);
    check("u6_full", full_o, 0);
    step(1'b1, 1'b0, 1'b0, mk(7));
    step(1'b1, 1'b0, 1'b0, mk(8));
    check("u8_full", full_o, 1);
    check("u8_usage", usage_o, 8);

    // Full: push with pop is accepted
    step(1'b1, 1'b1, 1'b0, mk(10));
    check("fpp_usage", usage_o, 8);
    check("fpp_head", log_o, mk(2));
    check("fpp_ovf", overflow_o, 0);
    // Full: push without pop is dropped
    step(1'b1, 1'b0, 1'b0, mk(9));
    check("drop_ovf", overflow_o, 1);
    check("drop_usage", usage_o, 8);
    check("drop_head", log_o, mk(2));

    // Drain: order 2..8 then 10
    for (int i = 2; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), log_o, mk(i));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("drain_last", log_o, mk(10));
    step(1'b0, 1'b1, 1'b0, '0);
    check("drain_empty", queue_empty_o, 1);
    step(1'b0, 1'b1, 1'b0, '0);
    check("pop_empty_usage", usage_o, 0);

    // Empty: push+pop accepts push only
    step(1'b1, 1'b1, 1'b0, mk(11));
    check("epp_usage", usage_o, 1);
    check("epp_head", log_o, mk(11));
    step(1'b0, 1'b1, 1'b0, '0);
    check("epp_empty", queue_empty_o, 1);

    // Wrap: fill 5, pop 5, then 10 pushes with interleaved pops
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, mk(20 + i));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap_pop_%0d", i), log_o, mk(20 + i));
      step(1'b0, 1'b1, 1'b0, '0);
    end
    for (int i = 0; i < 10; i++) begin
      logic pop;
      pop = (i % 2) == 1;
      if (pop) begin
        check($sformatf("wrap_head_%0d", i), log_o, mq[0]);
        void'(mq.pop_front());
      end
      mq.push_back(mk(30 + i));
      step(1'b1, pop, 1'b0, mk(30 + i));
      check($sformatf("wrap_usage_%0d", i), usage_o, mq.size());
    end
    while (mq.size() > 0) begin
      check("wrap_drain", log_o, mq[0]);
      void'(mq.pop_front());
      step(1'b0, 1'b1, 1'b0, '0);
      check("wrap_drain_usage", usage_o, mq.size());
    end

    // Flush keeps overflow
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, mk(40 + i));
    check("pre_flush_usage", usage_o, 3);
    step(1'b1, 1'b0, 1'b1, mk(45));
    check("flush_usage", usage_o, 0);
    check("flush_empty", queue_empty_o, 1);
    check("flush_ovf", overflow_o, 1);

    // Asynchronous reset mid-operation
    step(1'b1, 1'b0, 1'b0, mk(46));
    step(1'b1, 1'b0, 1'b0, mk(47));
    #2 rst_ni = 1'b0;
    #1;
    check("arst_usage", usage_o, 0);
    check("arst_ovf", overflow_o, 0);
    check("arst_empty", queue_empty_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b1, 1'b0, 1'b0, mk(50));
    check("post_rst_head", log_o, mk(50));
    check("post_rst_usage", usage_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
